// File: rtl/reg_context_ctrl.sv
// reg_context_ctrl
//   Save/restore sequencer for a masked subset of the 16 CPU registers,
//   used on call and interrupt entry/exit. The stack grows down and SP is
//   pre-decremented on push. While busy the block owns the register-file
//   write port and one read port and drives the data-memory port.
//
// Ports
//   clk, reset                       clock (rising edge), sync active-high reset
//   save_req, restore_req            start requests, sampled only when idle
//   reg_mask                         bit i selects register i, captured at accept
//   sp_in                            current SP from the register file
//   busy, done                       status; done is a one-cycle pulse
//   rf_read_reg / rf_read_data       async register-file read port
//   rf_write_reg / rf_write_data /
//   rf_reg_write                     register-file write port
//   mem_addr / mem_wdata / mem_we /
//   mem_re / mem_rdata               data-memory port, read data one cycle late
module reg_context_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter logic [3:0]  SP_REG   = 4'd14,
  parameter logic [3:0]  ZERO_REG = 4'd15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [15:0]       reg_mask,
  input  logic [DATA_W-1:0] sp_in,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [3:0]        rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE, S_RST_RD, S_RST_WR, S_SP_UPD, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       mask_q, mask_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic [15:0]       eff_mask;

  function automatic logic [3:0] hi_idx(input logic [15:0] m);
    hi_idx = '0;
    for (int unsigned i = 0; i < 16; i++)
      if (m[i]) hi_idx = 4'(i);
  endfunction

  function automatic logic [3:0] lo_idx(input logic [15:0] m);
    lo_idx = '0;
    for (int unsigned i = 16; i > 0; i--)
      if (m[i-1]) lo_idx = 4'(i - 1);
  endfunction

  always_comb begin
    eff_mask           = reg_mask;
    eff_mask[SP_REG]   = 1'b0;
    eff_mask[ZERO_REG] = 1'b0;
  end

  // Next state. The index of the register handled next is precomputed from
  // the remaining mask so that every output decodes from registered state:
  // highest set bit while saving, lowest set bit while restoring.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sp_d    = sp_q;
    unique case (state_q)
      S_IDLE: begin
        if (save_req || restore_req) begin
          mask_d = eff_mask;
          sp_d   = sp_in;
          if (eff_mask == '0)   state_d = S_DONE;
          else if (save_req)    state_d = S_SAVE;
          else                  state_d = S_RST_RD;
        end
      end
      S_SAVE: begin
        mask_d[idx_q] = 1'b0;
        sp_d          = sp_q - DATA_W'(1);
        if (mask_d == '0) state_d = S_SP_UPD;
      end
      S_RST_RD: state_d = S_RST_WR;
      S_RST_WR: begin
        mask_d[idx_q] = 1'b0;
        sp_d          = sp_q + DATA_W'(1);
        state_d       = (mask_d == '0) ? S_SP_UPD : S_RST_RD;
      end
      S_SP_UPD: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    idx_d = (state_d == S_SAVE) ? hi_idx(mask_d) : lo_idx(mask_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      sp_q    <= sp_d;
    end
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    rf_read_reg   = '0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    rf_reg_write  = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    unique case (state_q)
      S_SAVE: begin
        busy        = 1'b1;
        rf_read_reg = idx_q;
        mem_addr    = sp_q - DATA_W'(1);
        mem_wdata   = rf_read_data;
        mem_we      = 1'b1;
      end
      S_RST_RD: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = sp_q;
      end
      S_RST_WR: begin
        busy          = 1'b1;
        rf_write_reg  = idx_q;
        rf_write_data = mem_rdata;
        rf_reg_write  = 1'b1;
      end
      S_SP_UPD: begin
        busy          = 1'b1;
        rf_write_reg  = SP_REG;
        rf_write_data = sp_q;
        rf_reg_write  = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
